// File: rtl/mul_hilo_ctrl.sv
// Issue/sequencing controller for a pipelined 32x32 multiplier; owns the HI/LO registers.
// Define MUL_ACC_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate opcodes.
module mul_hilo_ctrl #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [3:0]  req_op_i,
   input  logic [31:0] req_a_i,
   input  logic [31:0] req_b_i,
   input  logic        flush_i,
   output logic [31:0] mul_a_o,
   output logic [31:0] mul_b_o,
   output logic        mul_signed_o,
   input  logic [63:0] mul_result_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        op_err_o
);

   localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CntW-1:0] CntInit = CntW'(MUL_LAT - 1);

   typedef enum logic [1:0] {StIdle, StWait, StCommit} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic            mul_signed_q, mul_signed_d;
   logic [31:0]     hi_q, hi_d, lo_q, lo_d;
   logic [63:0]     hilo_commit;

   logic op_mul, op_signed, op_mthi, op_mtlo, op_legal, accept;

`ifdef MUL_ACC_EN
   typedef enum logic [1:0] {AccNone, AccAdd, AccSub} acc_e;
   acc_e acc_q, acc_d, op_acc;
`endif

   always_comb begin
      op_mul    = 1'b0;
      op_signed = 1'b0;
      op_mthi   = 1'b0;
      op_mtlo   = 1'b0;
      op_legal  = 1'b1;
`ifdef MUL_ACC_EN
      op_acc    = AccNone;
`endif
      case (req_op_i)
         4'd0: begin op_mul = 1'b1; op_signed = 1'b1; end
         4'd1: op_mul = 1'b1;
`ifdef MUL_ACC_EN
         4'd2: begin op_mul = 1'b1; op_signed = 1'b1; op_acc = AccAdd; end
         4'd3: begin op_mul = 1'b1; op_acc = AccAdd; end
         4'd4: begin op_mul = 1'b1; op_signed = 1'b1; op_acc = AccSub; end
         4'd5: begin op_mul = 1'b1; op_acc = AccSub; end
`endif
         4'd6: op_mthi = 1'b1;
         4'd7: op_mtlo = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   // Flush in IDLE blocks acceptance of every opcode, including MTHI/MTLO.
   assign req_ready_o = (state_q == StIdle) && !flush_i;
   assign accept      = req_ready_o && req_valid_i;
   assign op_err_o    = accept && !op_legal;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = (state_q == StCommit) && !flush_i;

   always_comb begin
`ifdef MUL_ACC_EN
      case (acc_q)
         AccAdd:  hilo_commit = {hi_q, lo_q} + mul_result_i;
         AccSub:  hilo_commit = {hi_q, lo_q} - mul_result_i;
         default: hilo_commit = mul_result_i;
      endcase
`else
      hilo_commit = mul_result_i;
`endif
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      mul_signed_d = mul_signed_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
`ifdef MUL_ACC_EN
      acc_d        = acc_q;
`endif
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (op_mul) begin
                  mul_a_d      = req_a_i;
                  mul_b_d      = req_b_i;
                  mul_signed_d = op_signed;
`ifdef MUL_ACC_EN
                  acc_d        = op_acc;
`endif
                  cnt_d        = CntInit;
                  state_d      = StWait;
               end
               if (op_mthi) hi_d = req_a_i;
               if (op_mtlo) lo_d = req_a_i;
            end
         end
         StWait: begin
            if (flush_i) begin
               state_d = StIdle;
            end else if (cnt_q == '0) begin
               state_d = StCommit;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StCommit: begin
            state_d = StIdle;
            if (!flush_i) {hi_d, lo_d} = hilo_commit;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         mul_signed_q <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
`ifdef MUL_ACC_EN
         acc_q        <= AccNone;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         mul_signed_q <= mul_signed_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
`ifdef MUL_ACC_EN
         acc_q        <= acc_d;
`endif
      end
   end

   assign mul_a_o      = mul_a_q;
   assign mul_b_o      = mul_b_q;
   assign mul_signed_o = mul_signed_q;
   assign hi_o         = hi_q;
   assign lo_o         = lo_q;

endmodule
